// File: rtl/axi_transaction_pkg.sv
// Shared AXI-lite transaction types: protocol widths, payload typedefs and the
// write-master state encoding used by the master, monitors and benches.
package axi_transaction_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ID_W-1:0]   id_t;

  typedef enum logic [1:0] {
    WM_IDLE      = 2'd0,
    WM_ADDR_DATA = 2'd1,
    WM_RESP      = 2'd2
  } wm_state_t;

endpackage

// File: rtl/axi_timeout_counter.sv
// Saturating up-counter with synchronous clear; flags when LIMIT-1 is reached.
// Shared by write and read initiators to bound the wait for a response.
module axi_timeout_counter #(
  parameter int LIMIT = 64,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LP_LAST)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == LP_LAST);

endmodule

// File: rtl/axi_write_master.sv
// Single-outstanding AXI-lite write initiator: independent AW/W handshakes,
// then a B-response wait bounded by TIMEOUT_CYCLES.
//
// state        | meaning
// WM_IDLE      | req_ready high, waiting for a request
// WM_ADDR_DATA | awvalid/wvalid held until each handshakes
// WM_RESP      | bready high, waiting for bvalid or timeout
module axi_write_master
  import axi_transaction_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  req_valid,
  output logic  req_ready,
  input  addr_t req_addr,
  input  data_t req_data,
  output logic  done,
  output logic  done_timeout,
  output logic  unexpected_resp,
  output addr_t awaddr,
  output logic  awvalid,
  input  logic  awready,
  output data_t wdata,
  output logic  wvalid,
  input  logic  wready,
  input  logic  bvalid,
  output logic  bready
);

  wm_state_t r_state;
  logic      r_req_ready;
  logic      r_done;
  logic      r_done_timeout;
  logic      r_unexpected;
  addr_t     r_awaddr;
  data_t     r_wdata;
  logic      r_awvalid;
  logic      r_wvalid;
  logic      r_bready;

  logic w_aw_fin;
  logic w_w_fin;
  logic w_cnt_clear;
  logic w_cnt_en;
  logic w_expired;

  // A channel is finished once its valid is gone or handshakes this edge.
  assign w_aw_fin    = !r_awvalid || awready;
  assign w_w_fin     = !r_wvalid  || wready;
  assign w_cnt_clear = (r_state == WM_ADDR_DATA) && w_aw_fin && w_w_fin;
  assign w_cnt_en    = (r_state == WM_RESP) && !bvalid;

  axi_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= WM_IDLE;
      r_req_ready    <= 1'b0;
      r_done         <= 1'b0;
      r_done_timeout <= 1'b0;
      r_unexpected   <= 1'b0;
      r_awaddr       <= '0;
      r_wdata        <= '0;
      r_awvalid      <= 1'b0;
      r_wvalid       <= 1'b0;
      r_bready       <= 1'b0;
    end else begin
      r_done         <= 1'b0;
      r_done_timeout <= 1'b0;
      if (bvalid && (r_state != WM_RESP)) begin
        r_unexpected <= 1'b1;
      end
      case (r_state)
        WM_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_awaddr    <= req_addr;
            r_wdata     <= req_data;
            r_awvalid   <= 1'b1;
            r_wvalid    <= 1'b1;
            r_req_ready <= 1'b0;
            r_state     <= WM_ADDR_DATA;
          end
        end
        WM_ADDR_DATA: begin
          if (r_awvalid && awready) begin
            r_awvalid <= 1'b0;
          end
          if (r_wvalid && wready) begin
            r_wvalid <= 1'b0;
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= WM_RESP;
          end
        end
        WM_RESP: begin
          // A response on the last allowed cycle still wins over the timeout.
          if (bvalid) begin
            r_done      <= 1'b1;
            r_bready    <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= WM_IDLE;
          end else if (w_expired) begin
            r_done         <= 1'b1;
            r_done_timeout <= 1'b1;
            r_bready       <= 1'b0;
            r_req_ready    <= 1'b1;
            r_state        <= WM_IDLE;
          end
        end
        default: begin
          r_state <= WM_IDLE;
        end
      endcase
    end
  end

  assign req_ready       = r_req_ready;
  assign done            = r_done;
  assign done_timeout    = r_done_timeout;
  assign unexpected_resp = r_unexpected;
  assign awaddr          = r_awaddr;
  assign awvalid         = r_awvalid;
  assign wdata           = r_wdata;
  assign wvalid          = r_wvalid;
  assign bready          = r_bready;

endmodule
